// File: rtl/div_unit.sv
// Multicycle signed restoring divider: quotient on lo, remainder on hi.
// Ports:
//   clk       - rising-edge clock
//   reset     - asynchronous active-low reset
//   div_start - start request, honoured only while idle
//   data_a    - signed dividend
//   data_b    - signed divisor
//   busy      - high while a division is in progress
//   done      - one-cycle pulse when hi/lo hold a fresh result
//   div_zero  - one-cycle pulse when a start carried a zero divisor
//   hi        - remainder (sign follows the dividend)
//   lo        - quotient (truncated toward zero)
module div_unit #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             div_start,
   input  logic [WIDTH-1:0] data_a,
   input  logic [WIDTH-1:0] data_b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2
   } state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] quot;     // dividend shifts out the top, quotient bits shift in
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvs;
   logic             sign_q;
   logic             sign_r;

   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   trial;

   // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
   assign a_mag = data_a[WIDTH-1] ? (~data_a + WIDTH'(1)) : data_a;
   assign b_mag = data_b[WIDTH-1] ? (~data_b + WIDTH'(1)) : data_b;

   // One restoring step; trial[WIDTH] set means the subtract went negative.
   assign shifted = {rem, quot[WIDTH-1]};
   assign trial   = shifted - {1'b0, dvs};

   // Control FSM and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         cnt      <= '0;
         quot     <= '0;
         rem      <= '0;
         dvs      <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
      end else begin
         done     <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            S_IDLE: begin
               if (div_start) begin
                  if (data_b == '0) begin
                     div_zero <= 1'b1;
                  end else begin
                     quot   <= a_mag;
                     dvs    <= b_mag;
                     rem    <= '0;
                     cnt    <= '0;
                     sign_q <= data_a[WIDTH-1] ^ data_b[WIDTH-1];
                     sign_r <= data_a[WIDTH-1];
                     busy   <= 1'b1;
                     state  <= S_CALC;
                  end
               end
            end
            S_CALC: begin
               if (!trial[WIDTH]) begin
                  rem  <= trial[WIDTH-1:0];
                  quot <= {quot[WIDTH-2:0], 1'b1};
               end else begin
                  rem  <= shifted[WIDTH-1:0];
                  quot <= {quot[WIDTH-2:0], 1'b0};
               end
               if (cnt == CW'(WIDTH - 1)) begin
                  state <= S_FIX;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            S_FIX: begin
               lo    <= sign_q ? (~quot + WIDTH'(1)) : quot;
               hi    <= sign_r ? (~rem + WIDTH'(1)) : rem;
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: stimulus pushes expected results, a monitor
// pops and compares whenever done or div_zero is seen.
module tb_div_unit;

   logic        clk;
   logic        reset;
   logic        div_start;
   logic [31:0] data_a;
   logic [31:0] data_b;
   logic        busy;
   logic        done;
   logic        div_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   div_unit #(.WIDTH(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .div_start (div_start),
      .data_a    (data_a),
      .data_b    (data_b),
      .busy      (busy),
      .done      (done),
      .div_zero  (div_zero),
      .hi        (hi),
      .lo        (lo)
   );

   typedef struct {
      bit          zero;
      logic [31:0] hi;
      logic [31:0] lo;
      int          when;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad   = 0;
   int          cyc   = 0;
   int          bs    = -1000;   // edge count at which the current division started
   logic [31:0] last_hi = '0;
   logic [31:0] last_lo = '0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain signed arithmetic, truncating division, remainder follows dividend.
   task automatic issue(input logic [31:0] a, input logic [31:0] b);
      exp_t   e;
      longint sa;
      longint sb_v;
      int     t;
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      div_start = 1'b1;
      data_a    = a;
      data_b    = b;
      t = cyc + 1;
      if (t >= bs + 34) begin
         if (b == 32'd0) begin
            e.zero = 1'b1;
            e.hi   = last_hi;
            e.lo   = last_lo;
            e.when = t;
         end else begin
            e.zero  = 1'b0;
            e.lo    = 32'(sa / sb_v);
            e.hi    = 32'(sa % sb_v);
            e.when  = t + 33;
            last_hi = e.hi;
            last_lo = e.lo;
            bs      = t;
         end
         sb.push_back(e);
      end
      @(negedge clk);
      div_start = 1'b0;
      data_a    = $urandom;
      data_b    = $urandom;
   endtask

   task automatic wait_idle();
      while (cyc + 1 < bs + 34) @(negedge clk);
   endtask

   function automatic logic [31:0] pick();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0:       v = 32'd0;
         1:       v = 32'h8000_0000;
         2:       v = 32'hFFFF_FFFF;
         3:       v = 32'd1;
         4:       v = 32'($urandom_range(0, 20)) - 32'd10;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   // Monitor: busy profile every cycle, results whenever an output pulse appears.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         chk("busy", {31'd0, busy}, {31'd0, (cyc >= bs) && (cyc <= bs + 32)});
         if (done || div_zero) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_out: done=%b div_zero=%b with nothing expected (cycle %0d)",
                        done, div_zero, cyc);
            end else begin
               e = sb.pop_front();
               chk("div_zero", {31'd0, div_zero}, {31'd0, e.zero});
               chk("done", {31'd0, done}, {31'd0, !e.zero});
               chk("when", 32'(cyc), 32'(e.when));
               chk("hi", hi, e.hi);
               chk("lo", lo, e.lo);
            end
         end else if (sb.size() > 0 && cyc > sb[0].when) begin
            e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL missing_out: nothing seen, expected pulse at cycle %0d (now %0d)", e.when, cyc);
         end
      end
   end

   initial begin
      reset     = 1'b0;
      div_start = 1'b0;
      data_a    = '0;
      data_b    = '0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_lo", lo, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      issue(32'd7, 32'd2);
      wait_idle();
      issue(32'd5, 32'd0);
      repeat (3) @(negedge clk);
      issue(32'hFFFF_FFF9, 32'd2);
      wait_idle();
      issue(32'd7, 32'hFFFF_FFFE);
      wait_idle();
      issue(32'h8000_0000, 32'hFFFF_FFFF);
      wait_idle();

      // Start while busy is ignored; start on the done cycle is accepted.
      issue(32'd100, 32'd7);
      repeat (8) @(negedge clk);
      issue(32'd1, 32'd1);
      wait_idle();
      issue(32'd9, 32'd3);
      wait_idle();
      repeat (2) @(negedge clk);

      // Asynchronous reset in the middle of a division.
      issue(32'd12345, 32'd17);
      repeat (10) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      sb.delete();
      bs      = -1000;
      last_hi = '0;
      last_lo = '0;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      chk("mid_rst_dz", {31'd0, div_zero}, 32'd0);
      chk("mid_rst_hi", hi, 32'd0);
      chk("mid_rst_lo", lo, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);

      for (int i = 0; i < 200; i++) begin
         repeat ($urandom_range(0, 40)) @(negedge clk);
         issue(pick(), pick());
      end

      for (int k = 0; k < 100 && sb.size() > 0; k++) @(negedge clk);
      if (sb.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d results still outstanding, expected 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
